// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, default colour depth and test-pattern codes.
package vga_timing_pkg;

    localparam int unsigned TOTAL_COLS  = 800;
    localparam int unsigned TOTAL_ROWS  = 525;
    localparam int unsigned ACTIVE_COLS = 640;
    localparam int unsigned ACTIVE_ROWS = 480;
    localparam int unsigned COLOR_BITS  = 3;

    localparam logic [3:0] PAT_BLACK   = 4'd0;
    localparam logic [3:0] PAT_RED     = 4'd1;
    localparam logic [3:0] PAT_GREEN   = 4'd2;
    localparam logic [3:0] PAT_BLUE    = 4'd3;
    localparam logic [3:0] PAT_WHITE   = 4'd4;
    localparam logic [3:0] PAT_CHECKER = 4'd5;
    localparam logic [3:0] PAT_BARS    = 4'd6;
    localparam logic [3:0] PAT_BORDER  = 4'd7;
    localparam logic [3:0] PAT_SCROLL  = 4'd8;

endpackage

// File: rtl/vga_timing_counter.sv
// Free-running column/row raster counters with line-end and frame-end strobes.
module vga_timing_counter #(
    parameter int unsigned TOTAL_COLS = vga_timing_pkg::TOTAL_COLS,
    parameter int unsigned TOTAL_ROWS = vga_timing_pkg::TOTAL_ROWS
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [9:0] col_o,
    output logic [9:0] row_o,
    output logic       line_end_o,
    output logic       frame_end_o
);
    import vga_timing_pkg::*;

    localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);

    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       line_end;

    assign line_end = (col_q == COL_LAST);

    always_comb begin
        col_d = col_q + 10'd1;
        row_d = row_q;
        if (line_end) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 10'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o       = col_q;
    assign row_o       = row_q;
    assign line_end_o  = line_end;
    assign frame_end_o = line_end && (row_q == ROW_LAST);

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern source: registered raster counts, active-region flags and RGB.
// Optional macro VGA_PATTERN_FRAME_COUNT_EN adds a frame counter, o_Frame_Pulse and the scrolling checkerboard.
module vga_pattern_gen #(
    parameter int unsigned COLOR_BITS  = vga_timing_pkg::COLOR_BITS,
    parameter int unsigned TOTAL_COLS  = vga_timing_pkg::TOTAL_COLS,
    parameter int unsigned TOTAL_ROWS  = vga_timing_pkg::TOTAL_ROWS,
    parameter int unsigned ACTIVE_COLS = vga_timing_pkg::ACTIVE_COLS,
    parameter int unsigned ACTIVE_ROWS = vga_timing_pkg::ACTIVE_ROWS,
    parameter int unsigned BAR_WIDTH   = 80
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [3:0]            i_Pattern,
    output logic                  o_HSync,
    output logic                  o_VSync,
    output logic [9:0]            o_Col_Count,
    output logic [9:0]            o_Row_Count,
`ifdef VGA_PATTERN_FRAME_COUNT_EN
    output logic                  o_Frame_Pulse,
`endif
    output logic [COLOR_BITS-1:0] o_Red_Video,
    output logic [COLOR_BITS-1:0] o_Grn_Video,
    output logic [COLOR_BITS-1:0] o_Blu_Video
);
    import vga_timing_pkg::*;

    localparam logic [9:0] ACT_COLS  = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS  = 10'(ACTIVE_ROWS);
    localparam logic [9:0] EDGE_COL  = 10'(ACTIVE_COLS - 2);
    localparam logic [9:0] EDGE_ROW  = 10'(ACTIVE_ROWS - 2);
    localparam logic [9:0] BAR_LAST  = 10'(BAR_WIDTH - 1);

    logic [9:0] col, row;
    logic       line_end, frame_end;

    vga_timing_counter #(
        .TOTAL_COLS (TOTAL_COLS),
        .TOTAL_ROWS (TOTAL_ROWS)
    ) u_counter (
        .clk_i       (i_Clk),
        .rst_i       (i_Rst),
        .col_o       (col),
        .row_o       (row),
        .line_end_o  (line_end),
        .frame_end_o (frame_end)
    );

    logic [3:0]            pat_q;
    logic [9:0]            bar_cnt_q, bar_cnt_d;
    logic [2:0]            bar_q, bar_d;
    logic                  hs_q, vs_q;
    logic [9:0]            col_out_q, row_out_q;
    logic [COLOR_BITS-1:0] red_q, grn_q, blu_q;
    logic [COLOR_BITS-1:0] red_d, grn_d, blu_d;
    logic                  active, r_on, g_on, b_on;

    // Bar index tracks the current column without a divider; saturates past the last bar.
    always_comb begin
        bar_cnt_d = bar_cnt_q + 10'd1;
        bar_d     = bar_q;
        if (line_end) begin
            bar_cnt_d = '0;
            bar_d     = '0;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = '0;
            bar_d     = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
        end
    end

`ifdef VGA_PATTERN_FRAME_COUNT_EN
    logic [7:0] frame_q;
    logic       pulse_q;
    logic [9:0] scroll_col;

    assign scroll_col = col + {2'b00, frame_q};

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            frame_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            if (frame_end)
                frame_q <= frame_q + 8'd1;
            pulse_q <= (col == '0) && (row == '0);
        end
    end

    assign o_Frame_Pulse = pulse_q;
`endif

    always_comb begin
        active = (col < ACT_COLS) && (row < ACT_ROWS);
        r_on   = 1'b0;
        g_on   = 1'b0;
        b_on   = 1'b0;
        case (pat_q)
            PAT_RED:     r_on = 1'b1;
            PAT_GREEN:   g_on = 1'b1;
            PAT_BLUE:    b_on = 1'b1;
            PAT_WHITE:   {r_on, g_on, b_on} = 3'b111;
            PAT_CHECKER: {r_on, g_on, b_on} = {3{col[5] ^ row[5]}};
            PAT_BARS:    {r_on, g_on, b_on} = bar_q;
            PAT_BORDER:  {r_on, g_on, b_on} = {3{(col < 10'd2) || (col >= EDGE_COL) ||
                                                 (row < 10'd2) || (row >= EDGE_ROW)}};
`ifdef VGA_PATTERN_FRAME_COUNT_EN
            PAT_SCROLL:  {r_on, g_on, b_on} = {3{scroll_col[5] ^ row[5]}};
`endif
            default:     {r_on, g_on, b_on} = 3'b000;
        endcase
        red_d = (active && r_on) ? '1 : '0;
        grn_d = (active && g_on) ? '1 : '0;
        blu_d = (active && b_on) ? '1 : '0;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            pat_q     <= PAT_BLACK;
            bar_cnt_q <= '0;
            bar_q     <= '0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            col_out_q <= '0;
            row_out_q <= '0;
            red_q     <= '0;
            grn_q     <= '0;
            blu_q     <= '0;
        end else begin
            if (frame_end)
                pat_q <= i_Pattern;
            bar_cnt_q <= bar_cnt_d;
            bar_q     <= bar_d;
            hs_q      <= (col < ACT_COLS);
            vs_q      <= (row < ACT_ROWS);
            col_out_q <= col;
            row_out_q <= row;
            red_q     <= red_d;
            grn_q     <= grn_d;
            blu_q     <= blu_d;
        end
    end

    assign o_HSync     = hs_q;
    assign o_VSync     = vs_q;
    assign o_Col_Count = col_out_q;
    assign o_Row_Count = row_out_q;
    assign o_Red_Video = red_q;
    assign o_Grn_Video = grn_q;
    assign o_Blu_Video = blu_q;

endmodule
